// File: rtl/icache_pkg.sv
// Shared sizing and state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned LINE_WORDS = 32;
  localparam int unsigned NUM_LINES  = 8;
  localparam int unsigned OFF_W      = 5;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned TAG_W      = 22;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BLEN_W     = 16;
  localparam int unsigned RAM_AW     = IDX_W + OFF_W;
  localparam int unsigned RAM_DEPTH  = NUM_LINES * LINE_WORDS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and burst-memory-side signals of the instruction cache.
interface icache_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] icache_rdaddr;
  logic              icache_rdreq;
  logic [DATA_W-1:0] icache_dataout;
  logic              icache_valid;
  logic [ADDR_W-1:0] mem_rdaddr;
  logic              mem_rdreq;
  logic [DATA_W-1:0] mem_dataout;
  logic              mem_datavalid;
  logic [BLEN_W-1:0] mem_burstlen;

  modport master (
    output icache_rdaddr, icache_rdreq, mem_dataout, mem_datavalid, mem_burstlen,
    input  icache_dataout, icache_valid, mem_rdaddr, mem_rdreq
  );

  modport slave (
    input  icache_rdaddr, icache_rdreq, mem_dataout, mem_datavalid, mem_burstlen,
    output icache_dataout, icache_valid, mem_rdaddr, mem_rdreq
  );

endinterface

// File: rtl/icache_mem.sv
// Simple-dual-port word RAM: one write port, one registered read port with enable.
module icache_mem
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  // Read register holds its value when re is low so the cache output is stable.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache with single-burst line fill.
module icache
  import icache_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  icache_if.slave bus
);

  localparam int unsigned OFF_LSB = 2;
  localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  state_e state, next_state;

  logic [TAG_W-1:0]          tags [NUM_LINES];
  logic [NUM_LINES-1:0]      line_valid;
  logic [ADDR_W-1:OFF_LSB]   miss_word;
  logic [BLEN_W-1:0]         cnt;
  logic [IDX_W-1:0]          req_idx, miss_idx;
  logic [TAG_W-1:0]          req_tag;
  logic [BLEN_W-1:0]         burst_len_c;
  logic                      hit_c, beat_c, last_beat_c, ram_we_c, rd_en_c;
  logic [RAM_AW-1:0]         ram_waddr_c, ram_raddr_c;
  logic                      valid_q, valid_d;
  logic                      rdreq_q, rdreq_d;
  logic [ADDR_W-1:0]         rdaddr_q, rdaddr_d;
  logic                      unused_c;

  assign unused_c    = ^bus.icache_rdaddr[OFF_LSB-1:0];
  assign req_idx     = bus.icache_rdaddr[IDX_LSB +: IDX_W];
  assign req_tag     = bus.icache_rdaddr[TAG_LSB +: TAG_W];
  assign miss_idx    = miss_word[IDX_LSB +: IDX_W];
  assign hit_c       = line_valid[req_idx] && (tags[req_idx] == req_tag);
  assign burst_len_c = (bus.mem_burstlen == '0) ? BLEN_W'(LINE_WORDS) : bus.mem_burstlen;
  assign beat_c      = (state == FILL) && bus.mem_datavalid;
  assign last_beat_c = beat_c && (cnt == burst_len_c - BLEN_W'(1));
  // Surplus beats still count toward the burst length but never reach the RAM.
  assign ram_we_c    = beat_c && (cnt < BLEN_W'(LINE_WORDS));
  assign ram_waddr_c = {miss_idx, cnt[OFF_W-1:0]};
  assign rd_en_c     = ((state == IDLE) && bus.icache_rdreq && hit_c) || (state == RESP);
  assign ram_raddr_c = (state == RESP) ? {miss_idx, miss_word[OFF_LSB +: OFF_W]}
                                       : {req_idx, bus.icache_rdaddr[OFF_LSB +: OFF_W]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.icache_rdreq && !hit_c) next_state = REQ;
      REQ:     next_state = FILL;
      FILL:    if (last_beat_c) next_state = RESP;
      RESP:    next_state = DRAIN;
      DRAIN:   if (!bus.mem_datavalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = rd_en_c;
    rdreq_d  = (next_state == REQ);
    rdaddr_d = rdaddr_q;
    if ((state == IDLE) && (next_state == REQ))
      rdaddr_d = {bus.icache_rdaddr[ADDR_W-1:IDX_LSB], IDX_LSB'(0)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      rdreq_q  <= 1'b0;
      rdaddr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rdreq_q  <= rdreq_d;
      rdaddr_q <= rdaddr_d;
    end
  end

  // Miss bookkeeping: latched address, beat counter and line valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid <= '0;
      miss_word  <= '0;
      cnt        <= '0;
    end else begin
      if ((state == IDLE) && (next_state == REQ))
        miss_word <= bus.icache_rdaddr[ADDR_W-1:OFF_LSB];
      if (state == REQ) begin
        line_valid[miss_idx] <= 1'b0;
        cnt                  <= '0;
      end
      if (beat_c)      cnt <= cnt + BLEN_W'(1);
      if (last_beat_c) line_valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat_c) tags[miss_idx] <= miss_word[TAG_LSB +: TAG_W];
  end

  icache_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (bus.mem_dataout),
    .re    (rd_en_c),
    .raddr (ram_raddr_c),
    .rdata (bus.icache_dataout)
  );

  assign bus.icache_valid = valid_q;
  assign bus.mem_rdreq    = rdreq_q;
  assign bus.mem_rdaddr   = rdaddr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches against a burst memory model.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_if bus();

  icache dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] mreq_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          extra_beats = 0;
  resp_t       r;
  logic [31:0] line;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every icache_valid must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && bus.icache_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid with data 0x%08h at cycle %0d, required none",
                 bus.icache_dataout, cyc);
      end else begin
        r = resp_q.pop_front();
        check("resp_data", bus.icache_dataout, r.data);
        if (r.exp_cyc >= 0) check("resp_latency", 32'(cyc), 32'(r.exp_cyc));
      end
    end
  end

  // Burst request monitor.
  always @(negedge clk) begin
    if (!reset && bus.mem_rdreq) begin
      if (mreq_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_rdreq: got addr 0x%08h at cycle %0d, required none",
                 bus.mem_rdaddr, cyc);
      end else begin
        check("mem_rdaddr", bus.mem_rdaddr, mreq_q.pop_front());
      end
    end
  end

  // Memory model: word k of line A is {A[31:7], 2'b00, k[4:0]}, beats start one cycle after the request.
  initial begin
    bus.mem_datavalid = 1'b0;
    bus.mem_dataout   = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_rdreq) begin
        line = bus.mem_rdaddr;
        @(posedge clk); #2;
        for (int k = 0; k < 32 + extra_beats; k++) begin
          if (reset) break;
          bus.mem_dataout   = {line[31:7], 2'b00, 5'(k)};
          bus.mem_datavalid = 1'b1;
          @(posedge clk); #2;
        end
        bus.mem_datavalid = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a);
    bus.icache_rdaddr = a;
    bus.icache_rdreq  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drop();
    bus.icache_rdreq = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((resp_q.size() != 0 || mreq_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL timeout: got %0d responses and %0d bursts outstanding, required 0",
               resp_q.size(), mreq_q.size());
      resp_q.delete();
      mreq_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    resp_q.push_back('{data: d, exp_cyc: cyc + 1});
    issue(a);
  endtask

  task automatic miss(input logic [31:0] a, input logic [31:0] d);
    mreq_q.push_back({a[31:7], 7'b0});
    resp_q.push_back('{data: d, exp_cyc: -1});
    issue(a);
    drop();
    wait_quiet();
  endtask

  task automatic check_reset_outputs();
    check("rst_valid",      32'(bus.icache_valid), 32'h0);
    check("rst_dataout",    bus.icache_dataout,    32'h0);
    check("rst_mem_rdreq",  32'(bus.mem_rdreq),    32'h0);
    check("rst_mem_rdaddr", bus.mem_rdaddr,        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.icache_rdaddr = '0;
    bus.icache_rdreq  = 1'b0;
    bus.mem_burstlen  = 16'd32;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then hits in the filled line.
    miss(32'h0000_0000, 32'h0000_0000);
    hit(32'h0000_0000, 32'h0000_0000);
    hit(32'h0000_0004, 32'h0000_0001);
    drop();
    wait_quiet();

    // Back-to-back hits at one per cycle.
    hit(32'h0000_0008, 32'h0000_0002);
    hit(32'h0000_000C, 32'h0000_0003);
    hit(32'h0000_0010, 32'h0000_0004);
    hit(32'h0000_0018, 32'h0000_0006);
    drop();
    wait_quiet();

    // Conflict miss on index 0, then the original line misses again.
    miss(32'h2000_0000, 32'h2000_0000);
    miss(32'h0000_0000, 32'h0000_0000);

    // Request dropped during FILL, three surplus beats after the burst.
    extra_beats = 3;
    mreq_q.push_back(32'h0000_0100);
    resp_q.push_back('{data: 32'h0000_0100, exp_cyc: -1});
    issue(32'h0000_0100);
    drop();
    repeat (6) @(posedge clk);
    #1;
    issue(32'h0000_0104);
    drop();
    wait_quiet();
    extra_beats = 0;
    hit(32'h0000_0104, 32'h0000_0101);
    hit(32'h0000_017C, 32'h0000_011F);
    hit(32'h0000_0000, 32'h0000_0000);
    drop();
    wait_quiet();

    // Burst length 0 behaves as a full 32-beat line.
    bus.mem_burstlen = 16'd0;
    miss(32'h0000_0200, 32'h0000_0200);
    bus.mem_burstlen = 16'd32;
    hit(32'h0000_027C, 32'h0000_021F);
    drop();
    wait_quiet();

    // Reset in the middle of a fill aborts it and invalidates everything.
    mreq_q.push_back(32'h0000_0380);
    issue(32'h0000_0380);
    drop();
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    miss(32'h0000_0380, 32'h0000_0380);
    hit(32'h0000_0384, 32'h0000_0381);
    drop();
    wait_quiet();
    miss(32'h0000_0000, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
